// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator selecting redirect, stall hold, RAS return, predicted target or sequential step.
module pc_gen #(
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int RAS_DEPTH = 4,
  parameter bit C_EXT = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_interception,
  input  logic [ADDR_W-1:0] npc,
  input  logic              if_stall,
  input  logic              br_prd,
  input  logic [ADDR_W-1:0] npc_prd,
  input  logic              inst_c,
  input  logic              ras_push,
  input  logic              ras_pop,
  output logic [ADDR_W-1:0] if_pc_i,
  output logic              redirect_o,
  output logic              ras_empty,
  output logic              ras_full
);
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PW:0] CNT_MAX = RAS_DEPTH[PW:0];
  localparam logic [ADDR_W-1:0] ALIGN = C_EXT ? ~ADDR_W'(1) : ~ADDR_W'(3);
  logic [ADDR_W-1:0] r_pc, w_seq, w_top;
  logic [ADDR_W-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]     r_ptr, w_ptr_inc;
  logic [PW:0]       r_cnt;
  logic              r_redirect, w_pop, w_ras_en;
  assign w_seq     = r_pc + ((C_EXT && inst_c) ? ADDR_W'(2) : ADDR_W'(4));
  assign w_top     = r_ras[r_ptr];
  assign w_ptr_inc = r_ptr + PW'(1);
  assign ras_empty = r_cnt == '0;
  assign ras_full  = r_cnt == CNT_MAX;
  assign w_pop     = ras_pop && !ras_empty;
  assign w_ras_en  = !branch_interception && !if_stall;
  assign if_pc_i   = r_pc;
  assign redirect_o = r_redirect;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_redirect <= 1'b0;
      r_ptr      <= '0;
      r_cnt      <= '0;
    end else begin
      r_redirect <= branch_interception;
      if (branch_interception) begin
        r_pc  <= npc & ALIGN;
        r_ptr <= '0;
        r_cnt <= '0;
      end else if (!if_stall) begin
        r_pc <= w_pop ? (w_top & ALIGN) : br_prd ? (npc_prd & ALIGN) : w_seq;
        if (ras_push && !w_pop) begin
          r_ptr <= w_ptr_inc;
          r_cnt <= ras_full ? r_cnt : r_cnt + (PW+1)'(1);
        end else if (w_pop && !ras_push) begin
          r_ptr <= r_ptr - PW'(1);
          r_cnt <= r_cnt - (PW+1)'(1);
        end
      end
    end
  end
  // Push+pop on a non-empty stack replaces the top in place; a lone push writes one slot above.
  always_ff @(posedge clk) begin
    if (w_ras_en && ras_push)
      r_ras[w_pop ? r_ptr : w_ptr_inc] <= w_seq;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: scoreboard bench for pc_gen; C_EXT=1 instance u0 plus C_EXT=0 instance u1 for alignment.
module tb_pc_gen;
  logic clk, rst, bi, st, bp, ic, pu, po;
  logic [31:0] npc, nprd;
  logic [31:0] pc0, pc1;
  logic rd0, emp0, full0, rd1, emp1, full1;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] pc;
    logic rd;
    logic emp;
    logic full;
  } exp_t;
  exp_t q[$];
  exp_t e;

  pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .RAS_DEPTH(4), .C_EXT(1'b1)) u0 (
    .clk(clk), .rst(rst), .branch_interception(bi), .npc(npc), .if_stall(st),
    .br_prd(bp), .npc_prd(nprd), .inst_c(ic), .ras_push(pu), .ras_pop(po),
    .if_pc_i(pc0), .redirect_o(rd0), .ras_empty(emp0), .ras_full(full0));
  pc_gen #(.ADDR_W(32), .RESET_PC(32'h0), .RAS_DEPTH(4), .C_EXT(1'b0)) u1 (
    .clk(clk), .rst(rst), .branch_interception(bi), .npc(npc), .if_stall(st),
    .br_prd(bp), .npc_prd(nprd), .inst_c(ic), .ras_push(pu), .ras_pop(po),
    .if_pc_i(pc1), .redirect_o(rd1), .ras_empty(emp1), .ras_full(full1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic [31:0] n, input logic s, input logic p,
                       input logic [31:0] np, input logic c, input logic psh, input logic pp);
    bi = b; npc = n; st = s; bp = p; nprd = np; ic = c; pu = psh; po = pp;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    q.push_back('{32'h0, 1'b0, 1'b1, 1'b0});
    tick();
    e = q.pop_front(); n_chk++;
    if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
      n_fail++;
      $display("FAIL reset: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
    end
    rst = 1'b1;
  endtask

  task automatic test_sequential();
    logic [31:0] want [5] = '{32'h4, 32'h8, 32'hC, 32'hE, 32'h10};
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, 0, i >= 3, 0, 0);
      q.push_back('{want[i], 1'b0, 1'b1, 1'b0});
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
    end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 32'h103, 1, 0, 0, 0, 0, 0);
      q.push_back('{32'h102, i == 0, 1'b1, 1'b0});
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL redirect_stall[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
    end
  endtask

  task automatic test_ras_basic();
    logic [31:0] np [4] = '{32'h100, 32'h400, 32'h0, 32'h800};
    logic [31:0] want [4] = '{32'h100, 32'h400, 32'h404, 32'h104};
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, np[i], 0, i == 1 || i == 3, np[i], 0, i == 1, i == 3);
      q.push_back('{want[i], i == 0, i == 0 || i == 3, 1'b0});
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL ras_basic[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
    end
  endtask

  task automatic test_push_pop();
    logic       b   [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       p   [7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [31:0] np [7] = '{32'h100, 32'h400, 32'h0, 32'h0, 32'h600, 32'h700, 32'h0};
    logic       psh [7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       pp  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] want [7] = '{32'h100, 32'h400, 32'h104, 32'h404, 32'h600, 32'h700, 32'h604};
    logic       emp [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(b[i], np[i], 0, p[i], np[i], 0, psh[i], pp[i]);
      q.push_back('{want[i], b[i], emp[i], 1'b0});
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL push_pop[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
    end
  endtask

  task automatic test_ras_overflow();
    logic [31:0] ret [5];
    logic [31:0] cur = 32'h1000;
    drive(1, cur, 0, 0, 0, 0, 0, 0);
    q.push_back('{cur, 1'b1, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL overflow[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
      if (i < 5) begin
        ret[i] = cur + 32'd4;
        cur = 32'h2000 + 32'h100 * i;
        drive(0, 0, 0, 1, cur, 0, 1, 0);
        q.push_back('{cur, 1'b0, 1'b0, i >= 3});
      end else if (i < 9) begin
        cur = ret[9 - i];
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        q.push_back('{cur, 1'b0, i == 8, 1'b0});
      end else begin
        cur = cur + 32'd4;
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        q.push_back('{cur, 1'b0, 1'b1, 1'b0});
      end
    end
    tick();
    e = q.pop_front(); n_chk++;
    if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
      n_fail++;
      $display("FAIL overflow_empty_pop: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
    end
  endtask

  task automatic test_wrap_align();
    logic        b    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] np   [4] = '{32'hFFFF_FFFC, 32'h0, 32'h207, 32'h303};
    logic [31:0] want [4] = '{32'hFFFF_FFFC, 32'h0, 32'h206, 32'h302};
    logic [31:0] want1 [4] = '{32'hFFFF_FFFC, 32'h0, 32'h204, 32'h300};
    for (int i = 0; i < 4; i++) begin
      drive(b[i], np[i], 0, i == 3, np[i], 0, 0, 0);
      q.push_back('{want[i], b[i], 1'b1, 1'b0});
      q.push_back('{want1[i], b[i], 1'b1, 1'b0});
      tick();
      e = q.pop_front(); n_chk++;
      if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL wrap_align_c1[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
      end
      e = q.pop_front(); n_chk++;
      if ({pc1, rd1, emp1, full1} !== {e.pc, e.rd, e.emp, e.full}) begin
        n_fail++;
        $display("FAIL wrap_align_c0[%0d]: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", i, pc1, rd1, emp1, full1, e.pc, e.rd, e.emp, e.full);
      end
    end
  endtask

  task automatic test_async_reset();
    drive(1, 32'h100, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 1, 32'h400, 0, 1, 0);
    q.push_back('{32'h400, 1'b0, 1'b0, 1'b0});
    tick();
    e = q.pop_front(); n_chk++;
    if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
      n_fail++;
      $display("FAIL async_pre: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
    end
    drive(1, 32'h800, 0, 1, 32'h900, 0, 1, 0);
    #2 rst = 1'b0;
    q.push_back('{32'h0, 1'b0, 1'b1, 1'b0});
    #1;
    e = q.pop_front(); n_chk++;
    if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
      n_fail++;
      $display("FAIL async_assert: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b1;
    q.push_back('{32'h4, 1'b0, 1'b1, 1'b0});
    tick();
    e = q.pop_front(); n_chk++;
    if ({pc0, rd0, emp0, full0} !== {e.pc, e.rd, e.emp, e.full}) begin
      n_fail++;
      $display("FAIL async_release: got pc=%h rd=%b emp=%b full=%b want pc=%h rd=%b emp=%b full=%b", pc0, rd0, emp0, full0, e.pc, e.rd, e.emp, e.full);
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_sequential();
    test_redirect_stall();
    test_ras_basic();
    test_push_pop();
    test_ras_overflow();
    test_wrap_align();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
